// File: rtl/axis_lane_router.sv
`default_nettype none
// ============================================================================
// Module      : axis_lane_router
// Description : Registered AXI4-Stream lane router. Each beat is split into
//               LANE_COUNT lanes. Every output lane is driven independently
//               from any input lane, or forced to zero. The mapping is
//               captured per accepted beat. A 2-entry output/skid buffer
//               gives full throughput with registered ready and data.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_lane_router #(
   parameter int LANE_WIDTH = 16,
   parameter int LANE_COUNT = 2,
   parameter int SEL_WIDTH  = 1
) (
   input  logic                             aclk,
   input  logic                             reset,
   input  logic [LANE_COUNT*SEL_WIDTH-1:0]  lane_select,
   input  logic [LANE_COUNT-1:0]            lane_enable,
   input  logic [LANE_WIDTH*LANE_COUNT-1:0] S_AXIS_tdata,
   input  logic                             S_AXIS_tvalid,
   output logic                             S_AXIS_tready,
   input  logic                             M_AXIS_tready,
   output logic [LANE_WIDTH*LANE_COUNT-1:0] M_AXIS_tdata,
   output logic                             M_AXIS_tvalid,
   output logic [31:0]                      beat_count
);

   localparam int AXIS_TDATA_WIDTH = LANE_WIDTH * LANE_COUNT;
   localparam int C_MIN_SEL_WIDTH  = (LANE_COUNT > 2) ? $clog2(LANE_COUNT) : 1;

   // Selector fields must be wide enough to address every input lane
   generate
      if (SEL_WIDTH < C_MIN_SEL_WIDTH) begin : g_sel_width_check
         $error("axis_lane_router: SEL_WIDTH too small for LANE_COUNT");
      end
   endgenerate

   logic [AXIS_TDATA_WIDTH-1:0] w_routed;
   logic [SEL_WIDTH-1:0]        w_sel;
   logic                        w_accept;
   logic                        w_out_hs;

   logic [AXIS_TDATA_WIDTH-1:0] r_out_data;
   logic                        r_out_valid;
   logic [AXIS_TDATA_WIDTH-1:0] r_skid_data;
   logic                        r_skid_valid;
   logic                        r_s_ready;
   logic [31:0]                 r_beat_count;

   assign w_accept = S_AXIS_tvalid & r_s_ready;
   assign w_out_hs = r_out_valid & M_AXIS_tready;

   // Lane crossbar: a lane whose selector matches no input lane stays zero
   always_comb begin
      w_routed = '0;
      w_sel    = '0;
      for (int i = 0; i < LANE_COUNT; i++) begin
         w_sel = lane_select[i*SEL_WIDTH +: SEL_WIDTH];
         for (int k = 0; k < LANE_COUNT; k++) begin
            if (lane_enable[i] && (int'(w_sel) == k)) begin
               w_routed[i*LANE_WIDTH +: LANE_WIDTH] = S_AXIS_tdata[k*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Output/skid buffer; ready is registered from the next skid occupancy
   always_ff @(posedge aclk) begin
      if (reset) begin
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_skid_data  <= '0;
         r_skid_valid <= 1'b0;
         r_s_ready    <= 1'b0;
      end else begin
         r_s_ready <= 1'b1;
         if (w_out_hs) begin
            if (r_skid_valid) begin
               // ready was low, so no beat can arrive while the skid drains
               r_out_data   <= r_skid_data;
               r_skid_valid <= 1'b0;
            end else if (w_accept) begin
               r_out_data <= w_routed;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (!r_out_valid) begin
            if (w_accept) begin
               r_out_data  <= w_routed;
               r_out_valid <= 1'b1;
            end
         end else if (w_accept) begin
            // output stalled: park the beat and close the input
            r_skid_data  <= w_routed;
            r_skid_valid <= 1'b1;
            r_s_ready    <= 1'b0;
         end else if (r_skid_valid) begin
            r_s_ready <= 1'b0;
         end
      end
   end

   // Count output handshakes, wrapping naturally at 32 bits
   always_ff @(posedge aclk) begin
      if (reset) begin
         r_beat_count <= '0;
      end else if (w_out_hs) begin
         r_beat_count <= r_beat_count + 32'd1;
      end
   end

   assign S_AXIS_tready = r_s_ready;
   assign M_AXIS_tdata  = r_out_data;
   assign M_AXIS_tvalid = r_out_valid;
   assign beat_count    = r_beat_count;

endmodule
`default_nettype wire
